// File: rtl/stroke_undo_buffer.sv
// Circular history of painted pixels with stroke-granular undo/redo.
// Each entry holds {x, y, old colour, new colour, stroke-start flag}. An undo
// or redo replays one whole stroke as a registered valid/ready beat stream.
module stroke_undo_buffer #(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 3,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               save,
    input  logic               stroke_begin,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [COLOR_W-1:0] old_color_in,
    input  logic [COLOR_W-1:0] new_color_in,
    input  logic               undo,
    input  logic               redo,
    input  logic               restore_ready,
    output logic               restore_valid,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               restore_dir,
    output logic               restore_last,
    output logic               busy,
    output logic               can_undo,
    output logic               can_redo,
    output logic               overflow,
    output logic               save_dropped
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNDO_RUN = 2'd1,
        REDO_RUN = 2'd2
    } state_t;

    // cur/total count 0..DEPTH, so they carry one bit more than an index
    localparam logic [ADDR_W:0] ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [COORD_W-1:0] mem_x_r     [DEPTH];
    logic [COORD_W-1:0] mem_y_r     [DEPTH];
    logic [COLOR_W-1:0] mem_old_r   [DEPTH];
    logic [COLOR_W-1:0] mem_new_r   [DEPTH];
    logic               mem_first_r [DEPTH];

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] base_r, base_nxt_s;
    logic [ADDR_W:0]   cur_r, cur_nxt_s;
    logic [ADDR_W:0]   total_r, total_nxt_s;

    logic              accept_s;
    logic              wr_en_s;
    logic              wr_first_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              ld_s;
    logic              ld_dir_s;
    logic [ADDR_W:0]   ld_idx_s;
    logic              clr_s;
    logic              ovf_s;
    logic              drop_s;
    logic              ld_last_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W:0]   nx_idx_s;
    logic [ADDR_W-1:0] nx_addr_s;

    assign accept_s  = restore_valid & restore_ready;
    // When full, cur[ADDR_W-1:0] wraps to 0, so this lands on the oldest slot
    assign wr_addr_s = base_r + cur_r[ADDR_W-1:0];
    assign rd_addr_s = base_r + ld_idx_s[ADDR_W-1:0];
    assign nx_idx_s  = ld_idx_s + ONE;
    assign nx_addr_s = base_r + nx_idx_s[ADDR_W-1:0];

    // Next-state decode: history pointers, FSM, and which beat to load next
    always_comb begin
        state_nxt_s = state_r;
        base_nxt_s  = base_r;
        cur_nxt_s   = cur_r;
        total_nxt_s = total_r;
        wr_en_s     = 1'b0;
        wr_first_s  = stroke_begin;
        ld_s        = 1'b0;
        ld_dir_s    = 1'b0;
        ld_idx_s    = ZERO;
        clr_s       = 1'b0;
        ovf_s       = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (save) begin
                    wr_en_s = 1'b1;
                    if (cur_r == FULL) begin
                        base_nxt_s = base_r + 1'b1;
                        ovf_s      = 1'b1;
                    end else begin
                        wr_first_s  = stroke_begin | (cur_r == ZERO);
                        cur_nxt_s   = cur_r + ONE;
                        total_nxt_s = cur_r + ONE;
                    end
                end else if (undo && (cur_r != ZERO)) begin
                    state_nxt_s = UNDO_RUN;
                    ld_s        = 1'b1;
                    ld_dir_s    = 1'b0;
                    ld_idx_s    = cur_r - ONE;
                end else if (redo && (total_r > cur_r)) begin
                    state_nxt_s = REDO_RUN;
                    ld_s        = 1'b1;
                    ld_dir_s    = 1'b1;
                    ld_idx_s    = cur_r;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            UNDO_RUN: begin
                drop_s = save;
                if (accept_s) begin
                    cur_nxt_s = cur_r - ONE;
                    if (restore_last) begin
                        state_nxt_s = IDLE;
                        clr_s       = 1'b1;
                    end else begin
                        ld_s     = 1'b1;
                        ld_dir_s = 1'b0;
                        ld_idx_s = cur_r - TWO;
                    end
                end else begin
                    cur_nxt_s = cur_r;
                end
            end
            REDO_RUN: begin
                drop_s = save;
                if (accept_s) begin
                    cur_nxt_s = cur_r + ONE;
                    if (restore_last) begin
                        state_nxt_s = IDLE;
                        clr_s       = 1'b1;
                    end else begin
                        ld_s     = 1'b1;
                        ld_dir_s = 1'b1;
                        ld_idx_s = cur_r + ONE;
                    end
                end else begin
                    cur_nxt_s = cur_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                clr_s       = 1'b1;
            end
        endcase
    end

    // Last-beat flag for the beat being loaded: an undo stops on a stroke start
    // or the history floor, a redo stops before the next stroke start or the end
    always_comb begin
        ld_last_s = 1'b0;
        if (ld_dir_s) begin
            ld_last_s = (nx_idx_s == total_r) | mem_first_r[nx_addr_s];
        end else begin
            ld_last_s = mem_first_r[rd_addr_s] | (ld_idx_s == ZERO);
        end
    end

    // History storage; contents need no reset since cur/total gate every read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_x_r[wr_addr_s]     <= x_in;
            mem_y_r[wr_addr_s]     <= y_in;
            mem_old_r[wr_addr_s]   <= old_color_in;
            mem_new_r[wr_addr_s]   <= new_color_in;
            mem_first_r[wr_addr_s] <= wr_first_s;
        end
    end

    // Control state, status flags and the registered restore beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            base_r        <= '0;
            cur_r         <= ZERO;
            total_r       <= ZERO;
            restore_valid <= 1'b0;
            x_out         <= '0;
            y_out         <= '0;
            color_out     <= '0;
            restore_dir   <= 1'b0;
            restore_last  <= 1'b0;
            busy          <= 1'b0;
            can_undo      <= 1'b0;
            can_redo      <= 1'b0;
            overflow      <= 1'b0;
            save_dropped  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            base_r       <= base_nxt_s;
            cur_r        <= cur_nxt_s;
            total_r      <= total_nxt_s;
            busy         <= (state_nxt_s != IDLE);
            can_undo     <= (cur_nxt_s != ZERO);
            can_redo     <= (total_nxt_s > cur_nxt_s);
            overflow     <= ovf_s;
            save_dropped <= drop_s;
            if (ld_s) begin
                restore_valid <= 1'b1;
                x_out         <= mem_x_r[rd_addr_s];
                y_out         <= mem_y_r[rd_addr_s];
                color_out     <= ld_dir_s ? mem_new_r[rd_addr_s] : mem_old_r[rd_addr_s];
                restore_dir   <= ld_dir_s;
                restore_last  <= ld_last_s;
            end else if (clr_s) begin
                restore_valid <= 1'b0;
                restore_last  <= 1'b0;
            end else begin
                restore_valid <= restore_valid;
            end
        end
    end

endmodule

// File: tb/tb_stroke_undo_buffer.sv
// Directed bench for stroke_undo_buffer: stroke undo/redo, redo-tail discard,
// history overflow, backpressure, dropped saves and reset during replay.
module tb_stroke_undo_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       save = 1'b0;
    logic       stroke_begin = 1'b0;
    logic [7:0] x_in = 8'd0;
    logic [7:0] y_in = 8'd0;
    logic [2:0] old_color_in = 3'd0;
    logic [2:0] new_color_in = 3'd0;
    logic       undo = 1'b0;
    logic       redo = 1'b0;
    logic       restore_ready = 1'b0;
    logic       restore_valid;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic [2:0] color_out;
    logic       restore_dir;
    logic       restore_last;
    logic       busy;
    logic       can_undo;
    logic       can_redo;
    logic       overflow;
    logic       save_dropped;

    int n_checks = 0;
    int n_errors = 0;

    stroke_undo_buffer #(.COORD_W(8), .COLOR_W(3), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .save(save), .stroke_begin(stroke_begin),
        .x_in(x_in), .y_in(y_in), .old_color_in(old_color_in),
        .new_color_in(new_color_in), .undo(undo), .redo(redo),
        .restore_ready(restore_ready), .restore_valid(restore_valid),
        .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .restore_dir(restore_dir), .restore_last(restore_last), .busy(busy),
        .can_undo(can_undo), .can_redo(can_redo), .overflow(overflow),
        .save_dropped(save_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic save_px(input logic sb, input int x, input int y, input int oc, input int nc);
        save = 1'b1; stroke_begin = sb;
        x_in = 8'(x); y_in = 8'(y); old_color_in = 3'(oc); new_color_in = 3'(nc);
        @(negedge clk);
        save = 1'b0; stroke_begin = 1'b0;
    endtask

    task automatic pulse_undo();
        undo = 1'b1;
        @(negedge clk);
        undo = 1'b0;
    endtask

    task automatic pulse_redo();
        redo = 1'b1;
        @(negedge clk);
        redo = 1'b0;
    endtask

    // Check the beat visible now, then advance one cycle
    task automatic check_beat(input string tag, input int x, input int y, input int c,
                              input int d, input int l);
        check({tag, ".valid"}, 32'(restore_valid), 32'd1);
        check({tag, ".x"},     32'(x_out), 32'(x));
        check({tag, ".y"},     32'(y_out), 32'(y));
        check({tag, ".color"}, 32'(color_out), 32'(c));
        check({tag, ".dir"},   32'(restore_dir), 32'(d));
        check({tag, ".last"},  32'(restore_last), 32'(l));
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst.valid", 32'(restore_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.can_undo", 32'(can_undo), 32'd0);
        check("rst.can_redo", 32'(can_redo), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        restore_ready = 1'b1;

        // Stroke A, three pixels
        save_px(1'b1, 1, 1, 0, 5);
        save_px(1'b0, 2, 1, 0, 5);
        save_px(1'b0, 3, 1, 0, 5);
        check("a.can_undo", 32'(can_undo), 32'd1);
        check("a.can_redo", 32'(can_redo), 32'd0);
        pulse_undo();
        check("a.undo.busy", 32'(busy), 32'd1);
        check_beat("a.u0", 3, 1, 0, 0, 0);
        check_beat("a.u1", 2, 1, 0, 0, 0);
        check_beat("a.u2", 1, 1, 0, 0, 1);
        check("a.u.done", 32'(restore_valid), 32'd0);
        check("a.u.busy", 32'(busy), 32'd0);
        check("a.u.can_undo", 32'(can_undo), 32'd0);
        check("a.u.can_redo", 32'(can_redo), 32'd1);
        pulse_redo();
        check_beat("a.r0", 1, 1, 5, 1, 0);
        check_beat("a.r1", 2, 1, 5, 1, 0);
        check_beat("a.r2", 3, 1, 5, 1, 1);
        check("a.r.done", 32'(restore_valid), 32'd0);
        check("a.r.can_redo", 32'(can_redo), 32'd0);
        check("a.r.can_undo", 32'(can_undo), 32'd1);

        // Two strokes A and B
        do_reset();
        restore_ready = 1'b1;
        save_px(1'b1, 10, 20, 1, 2);
        save_px(1'b0, 11, 20, 1, 2);
        save_px(1'b1, 30, 40, 3, 4);
        save_px(1'b0, 31, 40, 3, 4);
        pulse_undo();
        check_beat("b.u0", 31, 40, 3, 0, 0);
        check_beat("b.u1", 30, 40, 3, 0, 1);
        check("b.u.done", 32'(restore_valid), 32'd0);
        check("b.u.can_undo", 32'(can_undo), 32'd1);
        check("b.u.can_redo", 32'(can_redo), 32'd1);
        pulse_redo();
        check_beat("b.r0", 30, 40, 4, 1, 0);
        check_beat("b.r1", 31, 40, 4, 1, 1);
        check("b.r.can_redo", 32'(can_redo), 32'd0);
        pulse_undo();
        check_beat("b.uu0", 31, 40, 3, 0, 0);
        check_beat("b.uu1", 30, 40, 3, 0, 1);
        pulse_undo();
        check_beat("a.uu0", 11, 20, 1, 0, 0);
        check_beat("a.uu1", 10, 20, 1, 0, 1);
        check("ab.can_undo", 32'(can_undo), 32'd0);
        check("ab.can_redo", 32'(can_redo), 32'd1);

        // Redo A only (stops before B's start), then a save discards B
        pulse_redo();
        check_beat("a.rr0", 10, 20, 2, 1, 0);
        check_beat("a.rr1", 11, 20, 2, 1, 1);
        check("tail.can_redo0", 32'(can_redo), 32'd1);
        save_px(1'b1, 50, 50, 6, 7);
        check("tail.can_redo", 32'(can_redo), 32'd0);
        check("tail.can_undo", 32'(can_undo), 32'd1);
        pulse_redo();
        check("tail.redo.valid", 32'(restore_valid), 32'd0);
        check("tail.redo.busy", 32'(busy), 32'd0);
        pulse_undo();
        check_beat("tail.u0", 50, 50, 6, 0, 1);
        check("tail.u.done", 32'(restore_valid), 32'd0);

        // Overflow: 17 single-pixel strokes into 16 entries
        do_reset();
        restore_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            save_px(1'b1, i, 0, 1, 2);
            check($sformatf("ovf.save%0d", i), 32'(overflow), (i == 17) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("ovf.pulse_end", 32'(overflow), 32'd0);
        check("ovf.can_redo", 32'(can_redo), 32'd0);
        for (int j = 0; j < 16; j++) begin
            pulse_undo();
            check_beat($sformatf("ovf.u%0d", j), 17 - j, 0, 1, 0, 1);
        end
        check("ovf.can_undo", 32'(can_undo), 32'd0);
        pulse_undo();
        check("ovf.floor.valid", 32'(restore_valid), 32'd0);

        // Backpressure and dropped save
        do_reset();
        save_px(1'b1, 5, 9, 2, 3);
        save_px(1'b0, 6, 9, 2, 3);
        save_px(1'b0, 7, 9, 2, 3);
        restore_ready = 1'b0;
        pulse_undo();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp.hold%0d.valid", k), 32'(restore_valid), 32'd1);
            check($sformatf("bp.hold%0d.x", k), 32'(x_out), 32'd7);
            check($sformatf("bp.hold%0d.last", k), 32'(restore_last), 32'd0);
            if (k == 1) begin
                save_px(1'b1, 99, 99, 1, 1);
                check("bp.dropped", 32'(save_dropped), 32'd1);
            end else begin
                @(negedge clk);
            end
        end
        check("bp.dropped_end", 32'(save_dropped), 32'd0);
        restore_ready = 1'b1;
        check_beat("bp.u0", 7, 9, 2, 0, 0);
        check_beat("bp.u1", 6, 9, 2, 0, 0);
        check_beat("bp.u2", 5, 9, 2, 0, 1);
        check("bp.can_undo", 32'(can_undo), 32'd0);
        pulse_redo();
        check_beat("bp.r0", 5, 9, 3, 1, 0);
        check_beat("bp.r1", 6, 9, 3, 1, 0);
        check_beat("bp.r2", 7, 9, 3, 1, 1);
        check("bp.can_redo", 32'(can_redo), 32'd0);

        // Reset during replay
        restore_ready = 1'b0;
        pulse_undo();
        check("rr.valid_pre", 32'(restore_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rr.valid", 32'(restore_valid), 32'd0);
        check("rr.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        restore_ready = 1'b1;
        @(negedge clk);
        check("rr.can_undo", 32'(can_undo), 32'd0);
        check("rr.can_redo", 32'(can_redo), 32'd0);
        pulse_undo();
        check("rr.no_beat", 32'(restore_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stroke_undo_buffer.md
Name: stroke_undo_buffer

Overview:
Parametrised successor to the single-pixel undo/redo store in the drawing pipeline. It keeps a circular history of painted pixels, each tagged with old and new colour and a stroke-start flag. Undo and redo replay one whole stroke at a time as a valid/ready pixel stream. The stream feeds the pixel mux and packet path ahead of the I2C readout.

Parameters:
COORD_W, 8, width of x/y coordinates
COLOR_W, 3, width of colour codes
DEPTH, 16, history entries; power of 2, minimum 4
ADDR_W, $clog2(DEPTH), index width (derived, do not override)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
save  input  1  one-cycle request to record a pixel
stroke_begin  input  1  sampled with save; 1 = this pixel starts a new stroke
x_in  input  COORD_W  pixel x
y_in  input  COORD_W  pixel y
old_color_in  input  COLOR_W  colour being overwritten; replayed on undo
new_color_in  input  COLOR_W  colour painted; replayed on redo
undo  input  1  one-cycle request to undo the last stroke
redo  input  1  one-cycle request to redo the next stroke
restore_ready  input  1  downstream accepts the current restore beat
restore_valid  output  1  restore beat present
x_out  output  COORD_W  restore pixel x
y_out  output  COORD_W  restore pixel y
color_out  output  COLOR_W  old colour (undo) or new colour (redo)
restore_dir  output  1  0 = undo beat, 1 = redo beat
restore_last  output  1  final beat of the stroke
busy  output  1  replay in progress (state != IDLE)
can_undo  output  1  cur != 0
can_redo  output  1  total > cur
overflow  output  1  one-cycle pulse when the oldest entry is discarded
save_dropped  output  1  one-cycle pulse when save arrives while busy

Behaviour:
- Storage: DEPTH entries of {x, y, old_color, new_color, first}. State registers: base (ADDR_W), cur (0..DEPTH), total (0..DEPTH). Logical entry i lives at physical (base+i) mod DEPTH.
- Reset: all outputs 0; base=cur=total=0; FSM=IDLE. Entry contents are don't-care. Reset mid-replay aborts immediately with no further beats.
- FSM states: IDLE, UNDO_RUN, REDO_RUN.
- IDLE priority within a cycle: save > undo > redo. A lower-priority request in the same cycle is ignored, not queued.
- Save in IDLE with cur<DEPTH: write at logical cur; cur<=cur+1; total<=cur+1, which discards any redo tail. first is set to stroke_begin, but is forced to 1 when cur==0.
- Save in IDLE with cur==DEPTH: base<=base+1 and the new entry overwrites the oldest slot; cur and total stay DEPTH; overflow pulses. The surviving oldest entry is not re-flagged, so undo stops at the history floor.
- Save while busy: not written; save_dropped pulses.
- Undo in IDLE with can_undo: go to UNDO_RUN. From the next cycle, present entry cur-1 with restore_dir=0 and color_out=old_color.
- Undo with can_undo=0: no effect.
- UNDO_RUN, on beat accept (valid & ready): cur<=cur-1. The beat is last (restore_last=1) if its first flag=1 or cur-1==0. After accepting the last beat, return to IDLE.
- Redo in IDLE with can_redo: go to REDO_RUN. Present entry cur with restore_dir=1 and color_out=new_color.
- Redo with can_redo=0: no effect.
- REDO_RUN, on beat accept: cur<=cur+1. The beat is last if cur+1==total or entry cur+1 has first=1. After accepting the last beat, return to IDLE.
- Handshake: beat outputs are registered and stay stable while restore_valid & !restore_ready. Throughput is 1 beat/cycle when ready is held high. Latency is request at cycle N, first restore_valid at N+1.
- undo/redo requests while busy are ignored.
- can_undo, can_redo and busy are registered, consistent with cur/total after each update.

Test Plan:
- Save stroke A: 3 pixels (1,1),(2,1),(3,1), first on pixel 1, old=0, new=5. Then undo with ready=1 -> 3 beats on consecutive cycles in order (3,1),(2,1),(1,1), color_out=0, restore_last on the 3rd beat. Ends with can_undo=0, can_redo=1.
- After the previous step, redo -> beats (1,1),(2,1),(3,1), color_out=5, dir=1, last on beat 3; can_redo=0.
- Strokes A (2 px) then B (2 px); undo -> only B's 2 beats; redo -> B's 2 beats. Then undo twice -> B, then A; cur=0.
- Undo B, then save new pixel -> total=cur+1 and can_redo=0. A later redo produces no beat.
- DEPTH=16 with 17 single-pixel strokes -> overflow pulses once on the 17th save, total=16. Undo ×16 drains fully; pixel #1 is never emitted.
- Backpressure and collisions:
  - Stall ready=0 for 4 cycles during undo -> beat held stable.
  - Save during replay -> save_dropped pulse, history unchanged.
  - rst_n low mid-replay -> restore_valid=0 at once; cur=total=0.
